mac_lane_ifm_gather: RTL and testbench

Parametrised input-feature-map gatherer for the MAC lane. It accepts narrow IFM beats of `N_IN` elements and packs them into one full lane word of `N_ELEMENT` elements, with a per-element valid mask and `inter_end`/`accum_end` tags. A word is flushed early when an end tag arrives. It sits between the IFM fetch/unpack stage and the MAC lane input, and generalises the fixed 64×11-bit lane IFM word to arbitrary element count and width.

---
 rtl/mac_lane_ifm_gather.sv | 132 +++++++++++++
 tb/tb_mac_lane_ifm_gather.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_ifm_gather.sv
// Packs N_IN-element IFM beats into one N_ELEMENT lane word with valid mask and end tags.
// Define MAC_LANE_GATHER_STAT_EN to build the emitted/partial word counters.
module mac_lane_ifm_gather #(
  parameter int unsigned W_ELEMENT = 11,
  parameter int unsigned N_ELEMENT = 64,
  parameter int unsigned N_IN      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           o_in_ready,
  input  logic [W_ELEMENT*N_IN-1:0]      i_data,
  input  logic [N_IN-1:0]                i_elem_valid,
  input  logic                           i_inter_end,
  input  logic                           i_accum_end,
  output logic                           o_valid,
  input  logic                           i_out_ready,
  output logic [W_ELEMENT*N_ELEMENT-1:0] o_data,
  output logic [N_ELEMENT-1:0]           o_elem_valid,
  output logic                           o_inter_end,
  output logic                           o_accum_end,
  output logic [31:0]                    o_stat_words,
  output logic [31:0]                    o_stat_partial
);

  localparam int unsigned N_SLOT = N_ELEMENT / N_IN;
  localparam int unsigned SLOT_W = (N_SLOT > 1) ? $clog2(N_SLOT) : 1;
  localparam int unsigned W_BEAT = W_ELEMENT * N_IN;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOT - 1);

  logic [SLOT_W-1:0]              slot, slot_n;
  logic [W_ELEMENT*N_ELEMENT-1:0] asm_data, asm_data_n;
  logic [N_ELEMENT-1:0]           asm_ev, asm_ev_n;
  logic                           asm_inter, asm_inter_n;
  logic                           asm_accum, asm_accum_n;
  logic                           pend, pend_n;
  logic                           accept, closes, xfer;

  assign o_in_ready = !pend || !o_valid || i_out_ready;
  assign accept     = i_valid && o_in_ready;
  assign closes     = (slot == LAST_SLOT) || i_inter_end || i_accum_end;
  assign xfer       = pend && (!o_valid || i_out_ready);

  // A transfer clears the assembly first so a beat accepted in the same cycle lands in slot 0.
  always_comb begin
    asm_data_n  = xfer ? '0 : asm_data;
    asm_ev_n    = xfer ? '0 : asm_ev;
    asm_inter_n = xfer ? 1'b0 : asm_inter;
    asm_accum_n = xfer ? 1'b0 : asm_accum;
    pend_n      = pend && !xfer;
    slot_n      = slot;
    if (accept) begin
      for (int unsigned s = 0; s < N_SLOT; s++) begin
        if (slot == SLOT_W'(s)) begin
          asm_data_n[s*W_BEAT +: W_BEAT] = i_data;
          asm_ev_n[s*N_IN +: N_IN]       = i_elem_valid;
        end
      end
      if (closes) begin
        pend_n      = 1'b1;
        slot_n      = '0;
        asm_inter_n = i_inter_end | i_accum_end;
        asm_accum_n = i_accum_end;
      end else begin
        slot_n = slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= '0;
      pend      <= 1'b0;
      asm_data  <= '0;
      asm_ev    <= '0;
      asm_inter <= 1'b0;
      asm_accum <= 1'b0;
    end else begin
      slot      <= slot_n;
      pend      <= pend_n;
      asm_data  <= asm_data_n;
      asm_ev    <= asm_ev_n;
      asm_inter <= asm_inter_n;
      asm_accum <= asm_accum_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_elem_valid <= '0;
      o_inter_end  <= 1'b0;
      o_accum_end  <= 1'b0;
    end else if (xfer) begin
      o_valid      <= 1'b1;
      o_data       <= asm_data;
      o_elem_valid <= asm_ev;
      o_inter_end  <= asm_inter;
      o_accum_end  <= asm_accum;
    end else if (o_valid && i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef MAC_LANE_GATHER_STAT_EN
  logic        asm_partial;
  logic [31:0] stat_words, stat_partial;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_partial  <= 1'b0;
      stat_words   <= '0;
      stat_partial <= '0;
    end else begin
      if (accept && closes) asm_partial <= (slot != LAST_SLOT);
      else if (xfer)        asm_partial <= 1'b0;
      if (xfer) begin
        stat_words <= stat_words + 32'd1;
        if (asm_partial) stat_partial <= stat_partial + 32'd1;
      end
    end
  end

  assign o_stat_words   = stat_words;
  assign o_stat_partial = stat_partial;
`else
  assign o_stat_words   = '0;
  assign o_stat_partial = '0;
`endif

endmodule

// File: tb/tb_mac_lane_ifm_gather.sv
// Scoreboard bench for mac_lane_ifm_gather: beat-list reference model, decoupled monitor.
module tb_mac_lane_ifm_gather;

  localparam int unsigned W  = 11;
  localparam int unsigned NE = 64;
  localparam int unsigned NI = 16;
  localparam int unsigned NS = NE / NI;
  localparam int unsigned WB = W * NI;
  localparam int unsigned WD = W * NE;
`ifdef MAC_LANE_GATHER_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk, rst;
  logic          i_valid, o_in_ready, i_inter_end, i_accum_end;
  logic [WB-1:0] i_data;
  logic [NI-1:0] i_elem_valid;
  logic          o_valid, i_out_ready, o_inter_end, o_accum_end;
  logic [WD-1:0] o_data;
  logic [NE-1:0] o_elem_valid;
  logic [31:0]   o_stat_words, o_stat_partial;

  mac_lane_ifm_gather #(.W_ELEMENT(W), .N_ELEMENT(NE), .N_IN(NI)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_data(i_data), .i_elem_valid(i_elem_valid), .i_inter_end(i_inter_end),
    .i_accum_end(i_accum_end), .o_valid(o_valid), .i_out_ready(i_out_ready),
    .o_data(o_data), .o_elem_valid(o_elem_valid), .o_inter_end(o_inter_end),
    .o_accum_end(o_accum_end), .o_stat_words(o_stat_words), .o_stat_partial(o_stat_partial)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  typedef struct { logic [WB-1:0] d; logic [NI-1:0] ev; } beat_t;
  typedef struct { logic [WD-1:0] d; logic [NE-1:0] ev; logic ie; logic ae; int unsigned tag; } word_t;

  beat_t       cur[$];
  word_t       exp_q[$];
  int unsigned cyc = 0;
  int unsigned words_rst = 0;
  int unsigned part_rst = 0;

  // Model: a word is the concatenation of the beats since the last close, zero padded.
  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      exp_q.delete();
      words_rst = 0;
      part_rst  = 0;
    end else begin
      cyc++;
      chk("in_ready", o_in_ready, (exp_q.size() < 2) || i_out_ready);
      chk("out_valid", o_valid, (exp_q.size() > 0) ? (exp_q[0].tag + 2 <= cyc) : 1'b0);
      if (o_valid && i_out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 1'b1, 1'b0);
        else begin
          word_t w;
          w = exp_q.pop_front();
          chk("o_data", o_data, w.d);
          chk("o_elem_valid", o_elem_valid, w.ev);
          chk("o_inter_end", o_inter_end, w.ie);
          chk("o_accum_end", o_accum_end, w.ae);
        end
      end
      if (i_valid && o_in_ready) begin
        beat_t b;
        b.d  = i_data;
        b.ev = i_elem_valid;
        cur.push_back(b);
        if (i_inter_end || i_accum_end || cur.size() == NS) begin
          word_t w;
          w.d  = '0;
          w.ev = '0;
          for (int k = 0; k < cur.size(); k++) begin
            w.d[k*WB +: WB]  = cur[k].d;
            w.ev[k*NI +: NI] = cur[k].ev;
          end
          w.ie  = i_inter_end | i_accum_end;
          w.ae  = i_accum_end;
          w.tag = cyc;
          exp_q.push_back(w);
          words_rst++;
          if (cur.size() < NS) part_rst++;
          cur.delete();
        end
      end
    end
  end

  task automatic drive(input logic [NI-1:0] ev, input logic ie, input logic ae);
    logic [31:0] r;
    for (int k = 0; k < NI; k++) begin
      r = $urandom;
      i_data[k*W +: W] = r[W-1:0];
    end
    i_elem_valid = ev;
    i_inter_end  = ie;
    i_accum_end  = ae;
    i_valid      = 1'b1;
  endtask

  task automatic send(input logic [NI-1:0] ev, input logic ie, input logic ae);
    int w = 0;
    drive(ev, ie, ae);
    @(negedge clk);
    while (!o_in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    i_valid     = 1'b0;
    i_inter_end = 1'b0;
    i_accum_end = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, '0);
    chk("rst_o_elem_valid", o_elem_valid, '0);
    chk("rst_tags", {o_inter_end, o_accum_end}, 2'b00);
    chk("rst_in_ready", o_in_ready, 1'b1);
    chk("rst_stats", {o_stat_words, o_stat_partial}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    i_out_ready = 1'b1;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) chk({name, "_drain_timeout"}, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk({name, "_stat_words"}, o_stat_words, STAT ? words_rst : 0);
    chk({name, "_stat_partial"}, o_stat_partial, STAT ? part_rst : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bit took;
    int sent, iters;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_elem_valid = '0;
    i_inter_end = 1'b0; i_accum_end = 1'b0; i_out_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 8; i++) send('1, 1'b0, 1'b0);
    drain("full");

    send('1, 1'b0, 1'b0);
    send('1, 1'b1, 1'b0);
    drain("early");

    send(16'h00FF, 1'b0, 1'b1);
    drain("accum");

    // Two words fill assembly and output; the ninth beat must stall until drain.
    i_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      send(r[NI-1:0], 1'b0, 1'b0);
    end
    r = $urandom;
    drive(r[NI-1:0], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall", o_in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", o_in_ready, 1'b1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      send(r[NI-1:0], 1'b0, 1'b0);
    end
    drain("bp");

    for (int i = 0; i < 3; i++) send('1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      send(r[NI-1:0], 1'b0, 1'b0);
    end
    drain("rst_mid");
    chk("rst_mid_words", words_rst, 1);

    took = 1'b1; sent = 0; iters = 0;
    @(posedge clk);
    #1;
    while ((sent < 200 || !took) && iters < 5000) begin
      if (took) begin
        if (sent < 200 && $urandom_range(0, 3) != 0) begin
          r = $urandom;
          if ($urandom_range(0, 7) == 0) r = '0;
          drive(r[NI-1:0], $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
          sent++;
        end else begin
          i_valid = 1'b0;
        end
      end
      i_out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      took = !i_valid || o_in_ready;
      @(posedge clk);
      #1;
      iters++;
    end
    if (iters >= 5000) chk("random_timeout", 1'b1, 1'b0);
    i_valid = 1'b0;
    i_out_ready = 1'b1;
    send('1, 1'b0, 1'b1);
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
